// File: rtl/wr_dec_seq.sv
// wr_dec_seq: buffered write-enable decoder for the register-file write-back path.
// Requests (select + per-source address lanes) are captured through a
// valid/ready handshake into a small FIFO, then drained one per cycle into a
// registered one-hot write-enable vector. Broadcast writes are emitted either
// as a single all-ones cycle or as a per-register sweep from the top bit down.
module wr_dec_seq #(
  parameter int NUM_DEST    = 20,
  parameter int ADDR_W      = 5,
  parameter int NUM_SRC     = 4,
  parameter int SEL_W       = 2,
  parameter int DEPTH       = 4,
  parameter int GAP_LO      = 19,
  parameter int GAP_HI      = 20,
  parameter int BCAST_ADDR  = 31,
  parameter int SWEEP_BCAST = 0
) (
  input  logic                        Clock,
  input  logic                        Reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [SEL_W-1:0]            req_sel,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  output logic [NUM_DEST-1:0]         wr_en,
  output logic                        wr_addr_err,
  output logic                        busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SW_W  = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam logic [NUM_DEST-1:0] TOP_BIT = {1'b1, {(NUM_DEST-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_DEST-1:0]    wr_en_q, wr_en_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;
  logic [SW_W-1:0]        sweep_idx_q, sweep_idx_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ADDR_W-1:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0]      mem_d [DEPTH];

  logic [ADDR_W-1:0]      lane_s;
  logic                   push_s;
  logic                   pop_s;
  logic [NUM_DEST:0]      dec_s;

  // Map an address to {unmapped flag, one-hot enable}. Addresses below the
  // hole map straight through; addresses above it are shifted down by the
  // hole size. Destination i drives bit NUM_DEST-i.
  function automatic logic [NUM_DEST:0] decode_addr(input logic [ADDR_W-1:0] a);
    int                  a_i;
    int                  idx;
    logic                ok;
    logic [NUM_DEST-1:0] oh;
    a_i = int'(a);
    if (GAP_LO > GAP_HI) begin
      idx = a_i;
    end else if ((a_i >= 32'sd1) && (a_i < GAP_LO)) begin
      idx = a_i;
    end else if (a_i > GAP_HI) begin
      idx = a_i - (GAP_HI - GAP_LO + 32'sd1);
    end else begin
      idx = 32'sd0;
    end
    ok = (idx >= 32'sd1) && (idx <= NUM_DEST);
    for (int b = 0; b < NUM_DEST; b++) begin
      oh[b] = ok && (b == (NUM_DEST - idx));
    end
    return {~ok, oh};
  endfunction

  // Pick the address lane named by the select code.
  always_comb begin
    lane_s = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      lane_s = (req_sel == SEL_W'(k)) ? src_addr[k*ADDR_W +: ADDR_W] : lane_s;
    end
  end

  // Handshake: readiness is a registered view of FIFO space, forced low in reset.
  assign req_ready = Reset_n & ready_q;

  // Next-state: FSM (IDLE pops/decodes, SWEEP walks the one-hot) plus FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    wr_en_d     = '0;
    err_d       = 1'b0;
    sweep_idx_d = sweep_idx_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_d       = mem_q;
    pop_s       = 1'b0;
    dec_s       = decode_addr(mem_q[rd_ptr_q]);

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop_s = 1'b1;
          if (mem_q[rd_ptr_q] == ADDR_W'(BCAST_ADDR)) begin
            if (SWEEP_BCAST != 0) begin
              wr_en_d     = TOP_BIT;
              sweep_idx_d = SW_W'(NUM_DEST - 1);
              state_d     = ST_SWEEP;
            end else begin
              wr_en_d = '1;
            end
          end else begin
            wr_en_d = dec_s[NUM_DEST-1:0];
            err_d   = dec_s[NUM_DEST];
          end
        end else begin
          wr_en_d = '0;
        end
      end
      ST_SWEEP: begin
        // The step that lands on bit 0 hands control back to IDLE so the
        // next entry pops right after the bit-0 cycle.
        wr_en_d     = wr_en_q >> 1;
        sweep_idx_d = sweep_idx_q - SW_W'(1);
        if (sweep_idx_q <= SW_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SWEEP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        wr_en_d     = '0;
        sweep_idx_d = '0;
      end
    endcase

    // Select code 0 completes the handshake but never occupies a slot.
    push_s = req_valid && req_ready && (req_sel != '0);
    if (push_s) begin
      mem_d[wr_ptr_q] = lane_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    ready_d = (count_d < CNT_W'(DEPTH));
    busy_d  = (count_d != '0) || (state_d == ST_SWEEP) || (wr_en_d != '0);
  end

  // State register with synchronous active-low reset; reset drops everything in flight.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      sweep_idx_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      sweep_idx_q <= sweep_idx_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr_err = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_wr_dec_seq.sv
// Bench for wr_dec_seq: two instances (single-cycle broadcast and sweep
// broadcast) share the request stimulus; each is tracked by its own
// queue-based reference model. A vector table, a few directed sequences and
// a randomized run follow.
module tb_wr_dec_seq;
  localparam int ND = 20;
  localparam int AW = 5;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam int DP = 4;
  localparam int BC = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              req_valid;
  logic [SW-1:0]     req_sel;
  logic [NS*AW-1:0]  src_addr;
  logic              rdy_a, rdy_b;
  logic [ND-1:0]     wr_a, wr_b;
  logic              err_a, err_b;
  logic              busy_a, busy_b;

  wr_dec_seq #(.SWEEP_BCAST(0)) dut_a (
    .Clock(clk), .Reset_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a),
    .req_sel(req_sel), .src_addr(src_addr), .wr_en(wr_a),
    .wr_addr_err(err_a), .busy(busy_a));

  wr_dec_seq #(.SWEEP_BCAST(1)) dut_b (
    .Clock(clk), .Reset_n(rst_n), .req_valid(req_valid), .req_ready(rdy_b),
    .req_sel(req_sel), .src_addr(src_addr), .wr_en(wr_b),
    .wr_addr_err(err_b), .busy(busy_b));

  int total = 0;
  int bad   = 0;

  // Reference model state, index 0 = single-cycle broadcast, 1 = sweep.
  int            m_q     [2][8];
  int            m_head  [2];
  int            m_n     [2];
  int            m_sweep [2];   // sweep bits still to be shown after the current one
  logic [ND-1:0] m_wr    [2];
  bit            m_err   [2];
  bit            m_rdy   [2];

  typedef struct {
    int          sel;
    int          addr;
    logic [19:0] exp_wr;
    logic        exp_err;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Default address map: 1..18 direct, 21.. shifted down by the 2-entry hole.
  function automatic logic [ND-1:0] ref_onehot(input int a, output bit err);
    int            pos;
    logic [ND-1:0] v;
    v   = '0;
    err = 1'b1;
    pos = -1;
    if (a >= 1 && a <= 18) pos = a;
    else if (a >= 21) pos = a - 2;
    if (pos >= 1 && pos <= ND) begin
      v[ND-pos] = 1'b1;
      err = 1'b0;
    end
    return v;
  endfunction

  task automatic model_edge(input int m);
    int            a;
    bit            e;
    logic [ND-1:0] one;
    one = 1;
    if (!rst_n) begin
      m_n[m] = 0; m_head[m] = 0; m_sweep[m] = 0; m_wr[m] = '0; m_err[m] = 0;
    end else begin
      m_err[m] = 0;
      if (m_sweep[m] > 0) begin
        m_sweep[m] = m_sweep[m] - 1;
        m_wr[m] = one << m_sweep[m];
      end else if (m_n[m] > 0) begin
        a = m_q[m][m_head[m]];
        m_head[m] = (m_head[m] + 1) % 8;
        m_n[m] = m_n[m] - 1;
        if (a == BC) begin
          if (m == 0) m_wr[m] = '1;
          else begin
            m_wr[m] = one << (ND - 1);
            m_sweep[m] = ND - 1;
          end
        end else begin
          m_wr[m] = ref_onehot(a, e);
          m_err[m] = e;
        end
      end else begin
        m_wr[m] = '0;
      end
      if (req_valid && m_rdy[m] && req_sel != 0) begin
        m_q[m][(m_head[m] + m_n[m]) % 8] = int'(src_addr[req_sel*AW +: AW]);
        m_n[m] = m_n[m] + 1;
      end
    end
  endtask

  // One clock: check ready before the edge, advance the models, check outputs after.
  task automatic step();
    @(negedge clk);
    for (int m = 0; m < 2; m++) m_rdy[m] = rst_n && (m_n[m] < DP);
    chk("ready_a", rdy_a, m_rdy[0]);
    chk("ready_b", rdy_b, m_rdy[1]);
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_edge(m);
    #1;
    chk("wr_a", wr_a, m_wr[0]);
    chk("err_a", err_a, m_err[0]);
    chk("busy_a", busy_a, (m_n[0] != 0) || (m_sweep[0] != 0) || (m_wr[0] != 0));
    chk("wr_b", wr_b, m_wr[1]);
    chk("err_b", err_b, m_err[1]);
    chk("busy_b", busy_b, (m_n[1] != 0) || (m_sweep[1] != 0) || (m_wr[1] != 0));
  endtask

  // Present a request; the unselected lanes carry random garbage.
  task automatic put(input int sel, input int addr, input bit v);
    logic [NS*AW-1:0] s;
    s = 20'($urandom);
    s[sel*AW +: AW] = AW'(addr);
    src_addr  = s;
    req_sel   = SW'(sel);
    req_valid = v;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    logic [ND-1:0] one;
    one = 1;
    for (int m = 0; m < 2; m++) begin
      m_head[m] = 0; m_n[m] = 0; m_sweep[m] = 0; m_wr[m] = '0; m_err[m] = 0; m_rdy[m] = 0;
    end
    tbl[0]  = '{2, 1,  20'h80000, 1'b0};
    tbl[1]  = '{2, 22, 20'h00001, 1'b0};
    tbl[2]  = '{2, 21, 20'h00002, 1'b0};
    tbl[3]  = '{0, 5,  20'h00000, 1'b0};
    tbl[4]  = '{3, 19, 20'h00000, 1'b1};
    tbl[5]  = '{3, 0,  20'h00000, 1'b1};
    tbl[6]  = '{1, 18, 20'h00004, 1'b0};
    tbl[7]  = '{1, 20, 20'h00000, 1'b1};
    tbl[8]  = '{2, 23, 20'h00000, 1'b1};
    tbl[9]  = '{3, 5,  20'h08000, 1'b0};
    tbl[10] = '{1, 31, 20'hFFFFF, 1'b0};

    // Reset, with a request present that must be dropped.
    rst_n = 1'b0;
    put(2, 7, 1);
    step();
    step();
    chk("rst_wr", wr_a, 20'h0);
    chk("rst_busy", busy_a, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Single requests through an idle block: output one cycle after accept.
    for (int i = 0; i < 11; i++) begin
      put(tbl[i].sel, tbl[i].addr, 1);
      step();
      req_valid = 1'b0;
      step();
      chk("tbl_wr", wr_a, tbl[i].exp_wr);
      chk("tbl_err", err_a, tbl[i].exp_err);
      step();
    end
    idle(25);

    // Sweep stalls the FIFO: four accepts fill it, ready stays low until the
    // pop after bit 0, and the first queued address follows the sweep.
    put(1, BC, 1);
    step();
    for (int k = 0; k < 6; k++) begin
      put(2, 5 + k, 1);
      step();
    end
    chk("full_ready_b", rdy_b, 1'b0);
    chk("full_busy_b", busy_b, 1'b1);
    for (int s = 7; s <= 24; s++) begin
      put(2, 10, 1);
      step();
      if (s == 20) chk("full_still_b", rdy_b, 1'b0);
      if (s == 21) begin
        chk("after_sweep_wr_b", wr_b, 20'h08000);
        chk("after_sweep_rdy_b", rdy_b, 1'b1);
      end
    end
    idle(30);

    // Reset in the middle of a sweep with entries queued.
    put(1, BC, 1);
    step();
    put(2, 3, 1); step();
    put(2, 4, 1); step();
    put(2, 5, 1); step();
    idle(4);
    rst_n = 1'b0;
    put(3, 7, 1);
    step();
    chk("midrst_wr_b", wr_b, 20'h0);
    chk("midrst_busy_b", busy_b, 1'b0);
    chk("midrst_rdy_b", rdy_b, 1'b0);
    rst_n = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("postrst_rdy_b", rdy_b, 1'b1);
    idle(25);

    // Back-to-back stream walking every destination from bit 19 to bit 0.
    for (int k = 0; k < 20; k++) begin
      put(1 + (k % 3), (k < 18) ? (k + 1) : (k + 3), 1);
      step();
      if (k >= 1) begin
        chk("stream_wr", wr_a, one << (ND - k));
        chk("stream_err", err_a, 1'b0);
      end
    end
    req_valid = 1'b0;
    step();
    chk("stream_last", wr_b, 20'h00001);
    idle(3);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      put($urandom_range(0, 3), $urandom_range(0, 31), ($urandom_range(0, 3) != 0));
      step();
    end
    rst_n = 1'b1;
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
